// File: rtl/ofdm_pkg.sv
// ofdm_pkg -- shared definitions for the OFDM symbol scheduler.
// Holds the default symbol geometry, counter widths and the scheduler
// state enumeration used by ofdm_sym_sched.
package ofdm_pkg;

  localparam int FFT_LEN_DEF = 64;   // useful samples per symbol
  localparam int CP_LEN_DEF  = 16;   // cyclic-prefix samples per symbol
  localparam int WD_MAX_DEF  = 256;  // FLUSH watchdog limit (enabled cycles)
  localparam int SAMP_W      = 7;    // width of the in-symbol sample index
  localparam int SYM_W       = 8;    // width of symbol counts

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } sched_state_t;

endpackage

// File: rtl/mod_counter.sv
// mod_counter -- enable-gated wrapping counter.
// Counts 0..MOD-1 on cycles with en=1 and wraps back to 0; clr has
// priority over en and returns the count to 0.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   clr  : synchronous clear
//   en   : count enable
//   cnt  : registered count value
module mod_counter #(
  parameter int W   = 8,
  parameter int MOD = 256
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  logic [W-1:0] r_cnt;
  logic         w_last;

  assign w_last = (r_cnt == W'(MOD - 1));
  assign cnt    = r_cnt;

  // wrapping count register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= w_last ? '0 : (r_cnt + W'(1));
    end else begin
      r_cnt <= r_cnt;
    end
  end

endmodule

// File: rtl/ofdm_sym_sched.sv
// ofdm_sym_sched -- frame scheduler for the OFDM source / cyclic-prefix /
// reverse-spectrum chain.
// A frame of num_sym symbols is fed sample by sample while downstream is
// ready (FEED), then the chain is drained until every symbol-start strobe
// has come back and a full symbol of tail has passed (FLUSH). A watchdog
// bounds FLUSH; DONE pulses for one cycle before returning to IDLE.
// Ports:
//   clk, rst     : clock (rising edge) and asynchronous active-low reset
//   start        : frame request pulse (accepted in IDLE only)
//   num_sym      : symbols per frame, latched on an accepted start
//   dn_ready     : downstream accepts a sample this cycle
//   dp_sop_out   : symbol-start strobe returned from the datapath output
//   dp_en        : clock enable to the chain (FEED/FLUSH and dn_ready)
//   dp_sop       : symbol-start strobe to the sample source
//   busy, done   : frame in progress / one-cycle completion pulse
//   err          : sticky error (watchdog expiry or surplus returned strobe)
//   sym_cnt      : symbols issued in this frame
//   samp_cnt     : sample index within the current symbol
module ofdm_sym_sched
  import ofdm_pkg::*;
#(
  parameter int FFT_LEN = FFT_LEN_DEF,
  parameter int CP_LEN  = CP_LEN_DEF,
  parameter int WD_MAX  = WD_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [SYM_W-1:0]  num_sym,
  input  logic              dn_ready,
  input  logic              dp_sop_out,
  output logic              dp_en,
  output logic              dp_sop,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [SYM_W-1:0]  sym_cnt,
  output logic [SAMP_W-1:0] samp_cnt
);

  localparam int SYM_LEN = FFT_LEN + CP_LEN;
  localparam int WD_W    = $clog2(WD_MAX + 1);
  localparam logic [SAMP_W-1:0] TAIL_MAX = SAMP_W'(SYM_LEN - 1);

  sched_state_t      r_state;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic [SYM_W-1:0]  r_num_sym;
  logic [SYM_W-1:0]  r_out_cnt;
  logic [SAMP_W-1:0] r_tail;
  logic [WD_W-1:0]   r_wd;

  logic              w_en;
  logic              w_feed_en;
  logic              w_flush_en;
  logic              w_start_ok;
  logic              w_samp_last;
  logic              w_sym_en;
  logic              w_feed_last;
  logic              w_sop_out_ok;
  logic              w_sop_out_excess;
  logic [SYM_W-1:0]  w_out_nxt;
  logic [SAMP_W-1:0] w_tail_nxt;
  logic              w_flush_ok;
  logic              w_wd_hit;

  assign w_en       = ((r_state == ST_FEED) || (r_state == ST_FLUSH)) && dn_ready;
  assign w_feed_en  = w_en && (r_state == ST_FEED);
  assign w_flush_en = w_en && (r_state == ST_FLUSH);
  assign w_start_ok = (r_state == ST_IDLE) && start && (num_sym != 8'd0);

  assign w_samp_last = (samp_cnt == TAIL_MAX);
  assign w_sym_en    = w_feed_en && w_samp_last;
  // the wrap that brings sym_cnt up to the latched count ends FEED
  assign w_feed_last = w_sym_en && ((sym_cnt + 8'd1) == r_num_sym);

  // A returned strobe beyond the expected count only flags an error; it
  // neither counts nor restarts the tail, so the frame timing is unchanged.
  assign w_sop_out_ok     = w_en && dp_sop_out && (r_out_cnt != r_num_sym);
  assign w_sop_out_excess = w_en && dp_sop_out && (r_out_cnt == r_num_sym);
  assign w_out_nxt        = w_sop_out_ok ? (r_out_cnt + 8'd1) : r_out_cnt;

  // next tail count: restart on a returned strobe, else saturating count
  always_comb begin
    w_tail_nxt = r_tail;
    if (w_sop_out_ok) begin
      w_tail_nxt = '0;
    end else if (w_en && (r_tail != TAIL_MAX)) begin
      w_tail_nxt = r_tail + 7'd1;
    end else begin
      w_tail_nxt = r_tail;
    end
  end

  // Exit conditions look at the counts including the current cycle, so the
  // transition happens on the cycle the last tail sample / watchdog tick lands.
  assign w_flush_ok = w_flush_en && (w_out_nxt == r_num_sym) && (w_tail_nxt == TAIL_MAX);
  assign w_wd_hit   = w_flush_en && (r_wd == WD_W'(WD_MAX - 1));

  assign dp_en  = w_en;
  assign dp_sop = w_feed_en && (samp_cnt == 7'd0);
  assign busy   = r_busy;
  assign done   = r_done;
  assign err    = r_err;

  mod_counter #(.W(SAMP_W), .MOD(SYM_LEN)) u_samp_cnt (
    .clk (clk),
    .rst (rst),
    .clr (w_start_ok),
    .en  (w_feed_en),
    .cnt (samp_cnt)
  );

  mod_counter #(.W(SYM_W), .MOD(256)) u_sym_cnt (
    .clk (clk),
    .rst (rst),
    .clr (w_start_ok),
    .en  (w_sym_en),
    .cnt (sym_cnt)
  );

  // returned-strobe, tail and watchdog counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_cnt <= '0;
      r_tail    <= '0;
      r_wd      <= '0;
    end else if (w_start_ok) begin
      r_out_cnt <= '0;
      r_tail    <= '0;
      r_wd      <= '0;
    end else begin
      r_out_cnt <= w_out_nxt;
      r_tail    <= w_tail_nxt;
      r_wd      <= w_flush_en ? (r_wd + WD_W'(1)) : r_wd;
    end
  end

  // scheduler state machine with registered busy/done/err
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_num_sym <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_sop_out_excess) begin
        r_err <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_start_ok) begin
            r_num_sym <= num_sym;
            r_err     <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= ST_FEED;
          end
        end
        ST_FEED: begin
          if (w_feed_last) begin
            r_state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (w_flush_ok) begin
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else if (w_wd_hit) begin
            r_done  <= 1'b1;
            r_err   <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ofdm_sym_sched.sv
// tb_ofdm_sym_sched -- self-checking bench for ofdm_sym_sched.
// Each started frame pushes its expected done cycle and err value; the
// monitor pops and compares whenever the DUT pulses done. A small model of
// the datapath returns dp_sop as dp_sop_out four cycles later.
module tb_ofdm_sym_sched;

  typedef struct {
    int   cyc;
    logic err;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] num_sym;
  logic       dn_ready;
  logic       dp_sop_out;
  logic       dp_en;
  logic       dp_sop;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] sym_cnt;
  logic [6:0] samp_cnt;

  int   n_checks;
  int   n_errors;
  int   cyc;
  int   base;
  int   sop_n;
  int   sop_first;
  bit   sop_seen [16];
  bit   freeze_on;
  bit   ret_en;
  int   extra_at;
  exp_t exp_q [$];

  ofdm_sym_sched #(.FFT_LEN(64), .CP_LEN(16), .WD_MAX(256)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .num_sym    (num_sym),
    .dn_ready   (dn_ready),
    .dp_sop_out (dp_sop_out),
    .dp_en      (dp_en),
    .dp_sop     (dp_sop),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .sym_cnt    (sym_cnt),
    .samp_cnt   (samp_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // free-running cycle index
  always @(posedge clk) cyc <= cyc + 1;

  // datapath return model and downstream backpressure
  always @(posedge clk) begin
    #2;
    dp_sop_out = (ret_en && sop_seen[(cyc - 4) & 15]) ||
                 ((extra_at >= 0) && ((cyc - base) == extra_at));
    dn_ready   = !(freeze_on && ((cyc - base) >= 40) && ((cyc - base) <= 49));
  end

  // monitor: record strobes, score done pulses
  always @(negedge clk) begin : mon
    exp_t e;
    sop_seen[cyc & 15] <= dp_sop;
    if ((cyc - base) == 0) begin
      sop_n     <= 0;
      sop_first <= -1;
    end else if (dp_sop) begin
      sop_n <= sop_n + 1;
      if (sop_first < 0) sop_first <= cyc - base;
    end
    if (done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("done_cycle", cyc - base, e.cyc);
        chk("done_err", int'(err), int'(e.err));
      end
    end
  end

  task automatic start_frame(input int n, input int exp_cyc, input logic exp_err, input bit push);
    exp_t e;
    @(posedge clk);
    #1;
    start   = 1'b1;
    num_sym = n[7:0];
    base    = cyc;
    if (push) begin
      e.cyc = exp_cyc;
      e.err = exp_err;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_rel(input int n);
    do @(negedge clk); while ((cyc - base) < n);
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (!done && (k < budget)) begin
      @(negedge clk);
      k++;
    end
    if (!done) chk("done_timeout", 0, 1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_dp_en"}, int'(dp_en), 0);
    chk({tag, "_dp_sop"}, int'(dp_sop), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_err"}, int'(err), 0);
    chk({tag, "_sym_cnt"}, int'(sym_cnt), 0);
    chk({tag, "_samp_cnt"}, int'(samp_cnt), 0);
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    cyc        = 0;
    base       = 0;
    sop_n      = 0;
    sop_first  = -1;
    freeze_on  = 1'b0;
    ret_en     = 1'b1;
    extra_at   = -1;
    rst        = 1'b0;
    start      = 1'b0;
    num_sym    = 8'd0;
    dn_ready   = 1'b1;
    dp_sop_out = 1'b0;

    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b1;

    // single symbol, no backpressure
    start_frame(1, 85, 1'b0, 1'b1);
    wait_rel(1);
    chk("s1_sop_c1", int'(dp_sop), 1);
    chk("s1_samp_c1", int'(samp_cnt), 0);
    wait_rel(81);
    chk("s1_sym_c81", int'(sym_cnt), 1);
    chk("s1_samp_c81", int'(samp_cnt), 0);
    chk("s1_sop_c81", int'(dp_sop), 0);
    wait_done(200);
    chk("s1_busy_c85", int'(busy), 1);
    @(negedge clk);
    chk("s1_busy_c86", int'(busy), 0);
    chk("s1_sop_count", sop_n, 1);
    chk("s1_sop_first", sop_first, 1);

    // three symbols with downstream stalled for cycles 40-49
    freeze_on = 1'b1;
    start_frame(3, 255, 1'b0, 1'b1);
    wait_rel(45);
    chk("s2_dp_en_stall", int'(dp_en), 0);
    chk("s2_samp_stall", int'(samp_cnt), 39);
    wait_rel(51);
    chk("s2_samp_resume", int'(samp_cnt), 40);
    wait_done(400);
    chk("s2_sym_cnt", int'(sym_cnt), 3);
    chk("s2_sop_count", sop_n, 3);
    freeze_on = 1'b0;

    // two symbols, strobes never returned: watchdog ends FLUSH
    ret_en = 1'b0;
    start_frame(2, 417, 1'b1, 1'b1);
    wait_done(600);
    @(negedge clk);
    chk("s3_busy_after", int'(busy), 0);
    chk("s3_err_sticky", int'(err), 1);
    ret_en = 1'b1;

    // zero-length request is ignored and leaves err alone
    start_frame(0, 0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("s4_busy_zero", int'(busy), 0);
    chk("s4_err_kept", int'(err), 1);

    // start pulsed mid-FEED does not disturb the running frame
    start_frame(2, 165, 1'b0, 1'b1);
    wait_rel(1);
    chk("s5_err_cleared", int'(err), 0);
    wait_rel(50);
    start   = 1'b1;
    num_sym = 8'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(300);
    chk("s5_sym_cnt", int'(sym_cnt), 2);

    // surplus returned strobe flags err, timing unchanged
    extra_at = 50;
    start_frame(1, 85, 1'b1, 1'b1);
    wait_done(200);
    extra_at = -1;

    // reset mid-FEED aborts the frame without done
    start_frame(3, 0, 1'b0, 1'b0);
    wait_rel(29);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk_all_zero("midrst");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    start_frame(1, 85, 1'b0, 1'b1);
    wait_done(200);
    chk("s7_sym_cnt", int'(sym_cnt), 1);

    @(negedge clk);
    chk("sb_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
